vector_list_sequencer: RTL and testbench

//  Display-list controller for the draw_line engine. Fetches 26-bit vector commands from a

---
 rtl/vector_list_sequencer.sv | 171 +++++++++++++++++
 tb/tb_vector_list_sequencer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_list_sequencer.sv
// rtl/vector_list_sequencer.sv - display-list sequencer feeding the draw_line engine
//
// Walks a synchronous list RAM of 26-bit vector commands {op[1:0], x[11:0], y[11:0]}
// (op: 00 DRAW, 01 JUMP, 10 HALT, 11 NOP) and turns each DRAW/JUMP into a one-cycle
// draw pulse with target x/y, waiting for draw_line's ready. All outputs are registered.
//
// Ports:
//   clk, reset                     system clock, synchronous active-low reset
//   start, stop                    begin a frame at address 0 / finish the current frame then idle
//   busy                           high whenever not idle
//   frame_done, frame_count        one-cycle pulse per frame end / completed frames (wraps)
//   err_overrun                    sticky: list ran past its last address without a HALT
//   list_rd, list_addr, list_data  list RAM read port, data valid the cycle after list_rd
//   draw, jump, x, y               command pulse to draw_line; x/y hold between commands
//   ready                          draw_line is idle and accepting
module vector_list_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int COORD_W = 12,
    parameter bit LOOP    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic               err_overrun,
    output logic               list_rd,
    output logic [ADDR_W-1:0]  list_addr,
    input  logic [25:0]        list_data,
    output logic               draw,
    output logic               jump,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    input  logic               ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_WAIT_RDY
    } state_t;

    localparam logic [1:0] OP_DRAW = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t      state;
    logic [25:0] cmd;
    logic        stop_req;
    logic [1:0]  op;
    logic        advance;
    logic        overrun;
    logic        frame_end;

    assign op = cmd[25:24];

    // advance: the current entry is finished and the next address is wanted.
    // Advancing from the last address means the list had no HALT; that ends the
    // frame exactly as a HALT would, but also flags the overrun.
    always_comb begin
        advance   = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_DECODE: begin
                if (op == OP_HALT) begin
                    frame_end = 1'b1;
                end else if (op == OP_NOP) begin
                    advance = 1'b1;
                end
            end
            S_WAIT_RDY: advance = ready;
            default: ;
        endcase
        overrun = advance && (list_addr == ADDR_LAST);
        if (overrun) begin
            frame_end = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cmd         <= '0;
            stop_req    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_overrun <= 1'b0;
            list_rd     <= 1'b0;
            list_addr   <= '0;
            draw        <= 1'b0;
            jump        <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            draw       <= 1'b0;
            jump       <= 1'b0;
            frame_done <= 1'b0;
            list_rd    <= 1'b0;

            // A stop while running is remembered and only honoured at frame end.
            if (state != S_IDLE && stop) begin
                stop_req <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        list_addr   <= '0;
                        err_overrun <= 1'b0;
                        stop_req    <= stop;
                        list_rd     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    cmd   <= list_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (op == OP_DRAW || op == OP_JUMP) begin
                        state <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (ready) begin
                        draw <= 1'b1;
                        jump <= (op == OP_JUMP);
                        x    <= COORD_W'(cmd[23:12]);
                        y    <= COORD_W'(cmd[11:0]);
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (advance && !overrun) begin
                list_addr <= list_addr + ADDR_W'(1);
                list_rd   <= 1'b1;
                state     <= S_FETCH;
            end

            if (frame_end) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
                if (overrun) begin
                    err_overrun <= 1'b1;
                end
                // A stop arriving in the very cycle the frame ends still counts.
                if (LOOP && !stop_req && !stop) begin
                    list_addr <= '0;
                    list_rd   <= 1'b1;
                    state     <= S_FETCH;
                end else begin
                    stop_req <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// tb/tb_vector_list_sequencer.sv - self-checking bench for vector_list_sequencer
module tb_vector_list_sequencer;

    localparam int AW    = 4;
    localparam int CW    = 12;
    localparam int DEPTH = 16;
    localparam logic [1:0] OP_DRAW = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef struct packed {
        logic        jmp;
        logic [11:0] cx;
        logic [11:0] cy;
    } cmd_t;

    typedef struct {
        logic [25:0] word;
        int          n_draw;
        int          n_jump;
        logic [11:0] ex;
        logic [11:0] ey;
        int          n_fetch;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic ready = 1'b1;
    logic sel   = 1'b0;
    logic [25:0] mem [DEPTH];

    logic start0, start1;
    logic busy0, busy1, fd0, fd1, err0, err1, rd0, rd1, draw0, draw1, jump0, jump1;
    logic [15:0] fc0, fc1;
    logic [AW-1:0] addr0, addr1;
    logic [CW-1:0] x0, x1, y0, y1;
    logic [25:0] rdata0, rdata1;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    always @(posedge clk) begin
        if (rd0) rdata0 <= mem[addr0];
        if (rd1) rdata1 <= mem[addr1];
    end

    vector_list_sequencer #(.ADDR_W(AW), .COORD_W(CW), .LOOP(1'b0)) u_once (
        .clk(clk), .reset(reset), .start(start0), .stop(stop), .busy(busy0),
        .frame_done(fd0), .frame_count(fc0), .err_overrun(err0), .list_rd(rd0),
        .list_addr(addr0), .list_data(rdata0), .draw(draw0), .jump(jump0),
        .x(x0), .y(y0), .ready(ready)
    );

    vector_list_sequencer #(.ADDR_W(AW), .COORD_W(CW), .LOOP(1'b1)) u_loop (
        .clk(clk), .reset(reset), .start(start1), .stop(stop), .busy(busy1),
        .frame_done(fd1), .frame_count(fc1), .err_overrun(err1), .list_rd(rd1),
        .list_addr(addr1), .list_data(rdata1), .draw(draw1), .jump(jump1),
        .x(x1), .y(y1), .ready(ready)
    );

    logic c_busy, c_fd, c_err, c_rd, c_draw, c_jump;
    logic [15:0] c_fc;
    logic [AW-1:0] c_addr;
    logic [CW-1:0] c_x, c_y;
    assign c_busy = sel ? busy1 : busy0;
    assign c_fd   = sel ? fd1 : fd0;
    assign c_err  = sel ? err1 : err0;
    assign c_rd   = sel ? rd1 : rd0;
    assign c_draw = sel ? draw1 : draw0;
    assign c_jump = sel ? jump1 : jump0;
    assign c_fc   = sel ? fc1 : fc0;
    assign c_addr = sel ? addr1 : addr0;
    assign c_x    = sel ? x1 : x0;
    assign c_y    = sel ? y1 : y0;

    // Observed activity of the selected DUT, plus the drawer model driving ready.
    cmd_t got[$];
    int draw_cyc[$];
    logic [AW-1:0] rd_addrs[$];
    int rd_cnt = 0, fd_cnt = 0, cyc = 0, last_draw_cyc = -100;
    int viol_ready = 0, viol_hold = 0, viol_gap = 0;
    int stall_mode = 0, busy_cnt = 0;
    bit hold_low = 1'b0;
    logic [CW-1:0] px = '0, py = '0;
    logic preset = 1'b0, psel = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset && preset && sel == psel) begin
            if (c_draw) begin
                got.push_back({c_jump, c_x, c_y});
                draw_cyc.push_back(cyc);
                if (!ready) viol_ready++;
                if (cyc - last_draw_cyc < 4) viol_gap++;
                last_draw_cyc = cyc;
            end else if (c_x != px || c_y != py) begin
                viol_hold++;
            end
            if (c_rd) begin
                rd_cnt++;
                rd_addrs.push_back(c_addr);
            end
            if (c_fd) fd_cnt++;
        end
        px = c_x;
        py = c_y;
        preset = reset;
        psel = sel;
        if (!reset) busy_cnt = 0;
        else if (c_draw) busy_cnt = (stall_mode < 0) ? int'($urandom_range(0, 6)) : stall_mode;
        else if (busy_cnt > 0) busy_cnt--;
        ready = !hold_low && busy_cnt == 0;
    end

    int total = 0, passed = 0;
    int exp_fc0 = 0, exp_fc1 = 0;
    cmd_t exp_q[$];
    logic [AW-1:0] exp_addrs[$];
    bit exp_ovr;
    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [25:0] mk(input logic [1:0] op, input int xv, input int yv);
        return {op, xv[11:0], yv[11:0]};
    endfunction

    function automatic cmd_t mkc(input logic j, input int xv, input int yv);
        return {j, xv[11:0], yv[11:0]};
    endfunction

    function automatic cmd_t got_at(input int i);
        if (i < got.size()) return got[i];
        return '1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < draw_cyc.size()) return draw_cyc[i];
        return -1000;
    endfunction

    task automatic fill(input logic [25:0] w);
        for (int i = 0; i < DEPTH; i++) mem[i] = w;
    endtask

    // Reference: one pass of the list by its rules, with no regard to timing.
    function automatic void model();
        exp_q.delete();
        exp_addrs.delete();
        exp_ovr = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            exp_addrs.push_back(a[AW-1:0]);
            if (mem[a][25:24] == OP_HALT) begin
                exp_ovr = 1'b0;
                break;
            end
            if (mem[a][25:24] != OP_NOP)
                exp_q.push_back({mem[a][25:24] == OP_JUMP, mem[a][23:12], mem[a][11:0]});
        end
    endfunction

    task automatic clear();
        got.delete();
        draw_cyc.delete();
        rd_addrs.delete();
        rd_cnt = 0;
        fd_cnt = 0;
        last_draw_cyc = -100;
    endtask

    task automatic launch(input int stop_at);
        clear();
        start = 1'b1;
        stop = (stop_at == 0);
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        if (stop_at > 0) begin
            tick(stop_at - 1);
            stop = 1'b1;
            tick(1);
            stop = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (c_busy && n < budget) begin
            tick(1);
            n++;
        end
        check(name, c_busy, 0);
    endtask

    task automatic cmp_model(input string name, input int frames);
        int bad = 0;
        check({name, " draw count"}, got.size(), exp_q.size() * frames);
        for (int i = 0; i < got.size() && exp_q.size() > 0; i++)
            if (got[i] != exp_q[i % exp_q.size()]) bad++;
        check({name, " draw content errors"}, bad, 0);
        check({name, " fetch count"}, rd_addrs.size(), exp_addrs.size() * frames);
        bad = 0;
        for (int i = 0; i < rd_addrs.size(); i++)
            if (rd_addrs[i] != exp_addrs[i % exp_addrs.size()]) bad++;
        check({name, " fetch address errors"}, bad, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        vecs[0] = '{mk(OP_DRAW, 'hABC, 'h123), 1, 0, 12'hABC, 12'h123, 2};
        vecs[1] = '{mk(OP_JUMP, 'hFFF, 'h000), 1, 1, 12'hFFF, 12'h000, 2};
        vecs[2] = '{mk(OP_NOP,  'h555, 'h555), 0, 0, 12'hFFF, 12'h000, 2};
        vecs[3] = '{mk(OP_HALT, 'h111, 'h222), 0, 0, 12'hFFF, 12'h000, 1};
        vecs[4] = '{mk(OP_DRAW, 'h000, 'hFFF), 1, 0, 12'h000, 12'hFFF, 2};
        vecs[5] = '{mk(OP_JUMP, 'h800, 'h7FF), 1, 1, 12'h800, 12'h7FF, 2};
        fill(mk(OP_HALT, 0, 0));

        // Reset state
        reset = 1'b0;
        tick(3);
        check("reset busy", c_busy, 0);
        check("reset draw", c_draw, 0);
        check("reset list_rd", c_rd, 0);
        check("reset frame_count", c_fc, 0);
        check("reset x", c_x, 0);
        check("reset y", c_y, 0);
        check("reset err", c_err, 0);
        check("reset addr", c_addr, 0);
        check("reset loop busy", busy1, 0);
        reset = 1'b1;
        tick(2);

        // Basic list, LOOP=0, ready high
        fill(mk(OP_HALT, 0, 0));
        mem[0] = mk(OP_DRAW, 10, 0);
        mem[1] = mk(OP_DRAW, 10, 10);
        mem[2] = mk(OP_JUMP, 0, 10);
        launch(-1);
        wait_idle(200, "t1 idle");
        exp_fc0++;
        check("t1 draw count", got.size(), 3);
        check("t1 draw0", got_at(0), mkc(0, 10, 0));
        check("t1 draw1", got_at(1), mkc(0, 10, 10));
        check("t1 draw2", got_at(2), mkc(1, 0, 10));
        check("t1 draw period", cyc_at(1) - cyc_at(0), 4);
        check("t1 frame_done", fd_cnt, 1);
        check("t1 frame_count", c_fc, exp_fc0);
        check("t1 fetches", rd_cnt, 4);
        tick(5);
        check("t1 x held", c_x, 0);
        check("t1 y held", c_y, 10);

        // Table of single-command lists
        for (int v = 0; v < 6; v++) begin
            fill(mk(OP_HALT, 0, 0));
            mem[0] = vecs[v].word;
            launch(-1);
            wait_idle(200, $sformatf("vec%0d idle", v));
            exp_fc0++;
            bad = 0;
            foreach (got[i]) if (got[i].jmp) bad++;
            check($sformatf("vec%0d draws", v), got.size(), vecs[v].n_draw);
            check($sformatf("vec%0d jumps", v), bad, vecs[v].n_jump);
            check($sformatf("vec%0d x", v), c_x, vecs[v].ex);
            check($sformatf("vec%0d y", v), c_y, vecs[v].ey);
            check($sformatf("vec%0d fetches", v), rd_cnt, vecs[v].n_fetch);
            check($sformatf("vec%0d frame_count", v), c_fc, exp_fc0);
        end

        // Slow drawer: ready low 20 cycles after each draw
        stall_mode = 20;
        fill(mk(OP_HALT, 0, 0));
        mem[0] = mk(OP_DRAW, 1, 2);
        mem[1] = mk(OP_JUMP, 3, 4);
        mem[2] = mk(OP_DRAW, 5, 6);
        mem[3] = mk(OP_DRAW, 7, 8);
        model();
        launch(-1);
        wait_idle(400, "t2 idle");
        exp_fc0++;
        cmp_model("t2", 1);
        bad = 0;
        for (int i = 1; i < draw_cyc.size(); i++) if (draw_cyc[i] - draw_cyc[i-1] != 21) bad++;
        check("t2 draw spacing errors", bad, 0);
        check("t2 draw while ready low", viol_ready, 0);
        stall_mode = 0;

        // LOOP=1, stop during frame 2
        sel = 1'b1;
        tick(1);
        fill(mk(OP_HALT, 0, 0));
        mem[0] = mk(OP_DRAW, 100, 200);
        mem[1] = mk(OP_JUMP, 300, 400);
        model();
        launch(-1);
        n = 0;
        while (got.size() < 3 && n < 200) begin tick(1); n++; end
        check("t3 reached frame 2", got.size(), 3);
        check("t3 still busy", c_busy, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle(200, "t3 idle");
        exp_fc1 += 2;
        check("t3 frame_count", c_fc, exp_fc1);
        check("t3 frame_done", fd_cnt, 2);
        cmp_model("t3", 2);
        tick(20);
        check("t3 no fetch after idle", rd_cnt, 6);

        // Overrun on the loop instance, stop just after start
        fill(mk(OP_NOP, 7, 7));
        launch(2);
        wait_idle(400, "t4 loop idle");
        exp_fc1++;
        check("t4 loop fetches", rd_cnt, 16);
        check("t4 loop err", c_err, 1);
        check("t4 loop frame_count", c_fc, exp_fc1);

        // Overrun on the one-shot instance; next start clears the flag
        sel = 1'b0;
        tick(1);
        launch(-1);
        wait_idle(400, "t4 idle");
        exp_fc0++;
        check("t4 fetches", rd_cnt, 16);
        check("t4 err", c_err, 1);
        check("t4 frame_done", fd_cnt, 1);
        check("t4 draws", got.size(), 0);
        mem[0] = mk(OP_HALT, 0, 0);
        launch(-1);
        check("t4 err cleared by start", c_err, 0);
        wait_idle(100, "t4b idle");
        exp_fc0++;
        check("t4b frame_count", c_fc, exp_fc0);

        // start while busy is ignored; NOP/HALT never draw
        stall_mode = 10;
        fill(mk(OP_HALT, 0, 0));
        mem[0] = mk(OP_DRAW, 9, 9);
        mem[1] = mk(OP_NOP, 1, 1);
        mem[2] = mk(OP_DRAW, 8, 8);
        model();
        launch(-1);
        tick(8);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(300, "t6 idle");
        exp_fc0++;
        cmp_model("t6", 1);
        check("t6 frame_done", fd_cnt, 1);
        stall_mode = 0;

        sel = 1'b1;
        tick(1);
        fill(mk(OP_HALT, 0, 0));
        mem[0] = mk(OP_NOP, 2, 2);
        mem[1] = mk(OP_DRAW, 4, 4);
        model();
        launch(-1);
        n = 0;
        while (fd_cnt < 1 && n < 100) begin tick(1); n++; end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (fd_cnt < 2 && n < 100) begin tick(1); n++; end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle(200, "t6 loop idle");
        exp_fc1 += 3;
        check("t6 loop frame_count", c_fc, exp_fc1);
        cmp_model("t6 loop", 3);

        // Reset while waiting for ready, then during a draw pulse
        sel = 1'b0;
        hold_low = 1'b1;
        tick(2);
        fill(mk(OP_HALT, 0, 0));
        mem[0] = mk(OP_DRAW, 'h123, 'h456);
        launch(-1);
        tick(6);
        check("t5 waiting busy", c_busy, 1);
        check("t5 no draw while ready low", got.size(), 0);
        reset = 1'b0;
        tick(1);
        check("t5 busy after reset", c_busy, 0);
        check("t5 draw after reset", c_draw, 0);
        check("t5 list_rd after reset", c_rd, 0);
        check("t5 frame_count after reset", c_fc, 0);
        reset = 1'b1;
        hold_low = 1'b0;
        exp_fc0 = 0;
        exp_fc1 = 0;
        tick(2);
        launch(-1);
        n = 0;
        while (!c_draw && n < 50) begin tick(1); n++; end
        check("t5 draw reached", c_draw, 1);
        reset = 1'b0;
        tick(1);
        check("t5 draw cut by reset", c_draw, 0);
        check("t5 busy cut by reset", c_busy, 0);
        check("t5 x reset", c_x, 0);
        check("t5 y reset", c_y, 0);
        reset = 1'b1;
        tick(2);

        // Randomized lists against the reference model
        stall_mode = -1;
        for (int it = 0; it < 40; it++) begin
            int r;
            sel = 1'($urandom_range(0, 1));
            tick(1);
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 9);
                mem[i] = mk(r < 4 ? OP_DRAW : r < 7 ? OP_JUMP : OP_NOP,
                            $urandom_range(0, 4095), $urandom_range(0, 4095));
            end
            if ($urandom_range(0, 4) != 0) mem[$urandom_range(0, DEPTH - 1)] = mk(OP_HALT, 0, 0);
            model();
            launch($urandom_range(0, 3));
            wait_idle(3000, $sformatf("rand%0d idle", it));
            if (sel) exp_fc1++;
            else exp_fc0++;
            cmp_model($sformatf("rand%0d", it), 1);
            check($sformatf("rand%0d err", it), c_err, exp_ovr);
            check($sformatf("rand%0d frame_done", it), fd_cnt, 1);
            check($sformatf("rand%0d frame_count", it), c_fc, sel ? exp_fc1 : exp_fc0);
        end

        check("draws while ready low", viol_ready, 0);
        check("x/y changed without draw", viol_hold, 0);
        check("draws closer than 4 cycles", viol_gap, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
